// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the fixed-message UART transmitter.
//   tx_state_t  : transmitter FSM states (GAP, START, DATA, PARITY, STOP)
//   DATA_BITS   : data bits per frame
//   MSG0..MSG3  : default message bytes, sent in index order
//   even_parity : parity bit that makes the count of 1s in data+parity even
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        GAP    = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int DATA_BITS = 8;

    localparam logic [7:0] MSG0 = 8'hAA;
    localparam logic [7:0] MSG1 = 8'h55;
    localparam logic [7:0] MSG2 = 8'hCC;
    localparam logic [7:0] MSG3 = 8'h89;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Free-running bit-period divider. Counts 0..BAUD_DIV-1 and wraps; bit_tick is
// high for the single cycle in which the count sits at BAUD_DIV-1, so every
// register enabled by it updates exactly once per bit period.
// Ports:
//   clk      : system clock
//   reset    : asynchronous, active-high; returns the count to 0
//   bit_tick : one-cycle pulse per bit period
// BAUD_DIV must be at least 2 so that bit_tick is low while in reset.
// -----------------------------------------------------------------------------
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 217
) (
    input  logic clk,
    input  logic reset,
    output logic bit_tick
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] count;

    assign bit_tick = (count == CW'(BAUD_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (bit_tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Stand-alone UART transmitter that repeats a fixed 4-byte message forever.
// Frame: start(0), 8 data bits LSB first, optional even parity, stop(1),
// followed by GAP_BITS idle (mark) bit periods before the next frame.
// Ports:
//   clk      : system clock (25 MHz nominal)
//   reset    : asynchronous, active-high; aborts any frame, line returns to mark
//   txd      : serial line, registered, idle high
//   tx_busy  : registered, high from start bit through stop bit
//   byte_idx : index of the byte being sent (or next to be sent)
// All state, including the registered line level, advances only on bit_tick,
// so each line level lasts a whole number of bit periods.
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int         BAUD_DIV  = 217,
    parameter int         PARITY_EN = 1,
    parameter int         GAP_BITS  = 2,
    parameter logic [7:0] MSG0      = uart_pkg::MSG0,
    parameter logic [7:0] MSG1      = uart_pkg::MSG1,
    parameter logic [7:0] MSG2      = uart_pkg::MSG2,
    parameter logic [7:0] MSG3      = uart_pkg::MSG3
) (
    input  logic       clk,
    input  logic       reset,
    output logic       txd,
    output logic       tx_busy,
    output logic [1:0] byte_idx
);

    // The bit counter is shared between the idle gap and the data bits.
    localparam int CNT_MAX = (GAP_BITS > DATA_BITS) ? GAP_BITS : DATA_BITS;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    logic                 bit_tick;
    tx_state_t            state, state_nx;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_nx;
    logic [DATA_BITS-1:0] shift, shift_nx;
    logic                 txd_nx, busy_nx;
    logic [1:0]           idx_nx;
    logic [DATA_BITS-1:0] cur_msg;

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .bit_tick (bit_tick)
    );

    // Message ROM; byte_idx only moves at the end of a frame, so cur_msg is
    // stable for the whole frame and can feed the parity bit directly.
    always_comb begin
        cur_msg = MSG0;
        unique case (byte_idx)
            2'd0: cur_msg = MSG0;
            2'd1: cur_msg = MSG1;
            2'd2: cur_msg = MSG2;
            2'd3: cur_msg = MSG3;
            default: cur_msg = MSG0;
        endcase
    end

    // Next-state logic. The *_nx values describe what the line and counters
    // become at the next bit_tick, which keeps txd/tx_busy registered.
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shift_nx   = shift;
        txd_nx     = txd;
        busy_nx    = tx_busy;
        idx_nx     = byte_idx;
        unique case (state)
            GAP: begin
                if (bit_cnt == CNT_W'(GAP_BITS - 1)) begin
                    state_nx   = START;
                    bit_cnt_nx = '0;
                    shift_nx   = cur_msg;
                    txd_nx     = 1'b0;
                    busy_nx    = 1'b1;
                end else begin
                    bit_cnt_nx = bit_cnt + 1'b1;
                end
            end
            START: begin
                state_nx   = DATA;
                bit_cnt_nx = '0;
                txd_nx     = shift[0];
            end
            DATA: begin
                if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
                    bit_cnt_nx = '0;
                    if (PARITY_EN != 0) begin
                        state_nx = PARITY;
                        txd_nx   = even_parity(cur_msg);
                    end else begin
                        state_nx = STOP;
                        txd_nx   = 1'b1;
                    end
                end else begin
                    // shift[1] is the bit that lands in shift[0] after this shift
                    shift_nx   = shift >> 1;
                    bit_cnt_nx = bit_cnt + 1'b1;
                    txd_nx     = shift[1];
                end
            end
            PARITY: begin
                state_nx = STOP;
                txd_nx   = 1'b1;
            end
            STOP: begin
                state_nx   = GAP;
                bit_cnt_nx = '0;
                txd_nx     = 1'b1;
                busy_nx    = 1'b0;
                idx_nx     = byte_idx + 1'b1;
            end
            default: begin
                state_nx   = GAP;
                bit_cnt_nx = '0;
                txd_nx     = 1'b1;
                busy_nx    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= GAP;
        end else if (bit_tick) begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt  <= '0;
            shift    <= '0;
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
            byte_idx <= 2'd0;
        end else if (bit_tick) begin
            bit_cnt  <= bit_cnt_nx;
            shift    <= shift_nx;
            txd      <= txd_nx;
            tx_busy  <= busy_nx;
            byte_idx <= idx_nx;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Three transmitters share clock and reset:
//   ch0: BAUD_DIV=4,   PARITY_EN=1, GAP_BITS=2
//   ch1: BAUD_DIV=4,   PARITY_EN=0, GAP_BITS=2
//   ch2: BAUD_DIV=217, PARITY_EN=1, GAP_BITS=2
// At every reset release the expected frames that will finish before the next
// reset are pushed into per-channel queues (start time, byte, parity, index).
// A negedge monitor decodes each line independently and pops on each frame.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    typedef struct packed {
        int         start;
        logic [7:0] data;
        logic       par;
        logic [1:0] idx;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       txd0, txd1, txd2;
    logic       busy0, busy1, busy2;
    logic [1:0] idx0, idx1, idx2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rel_cyc  = 0;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    exp_t exp_q2[$];

    logic [7:0] msgs[4] = '{8'hAA, 8'h55, 8'hCC, 8'h89};
    int         baud_a[3] = '{4, 4, 217};
    int         nb_a[3]   = '{11, 10, 11};

    // monitor state per channel
    logic        prev_t[3];
    logic        prev_b[3];
    int          busy_run[3];
    int          in_frame[3];
    int          start_c[3];
    logic [10:0] bits_a[3];
    logic [1:0]  idx_seen[3];

    uart_tx #(.BAUD_DIV(4), .PARITY_EN(1), .GAP_BITS(2)) dut0 (
        .clk(clk), .reset(reset), .txd(txd0), .tx_busy(busy0), .byte_idx(idx0));
    uart_tx #(.BAUD_DIV(4), .PARITY_EN(0), .GAP_BITS(2)) dut1 (
        .clk(clk), .reset(reset), .txd(txd1), .tx_busy(busy1), .byte_idx(idx1));
    uart_tx #(.BAUD_DIV(217), .PARITY_EN(1), .GAP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .txd(txd2), .tx_busy(busy2), .byte_idx(idx2));

    // ---------------- clock / cycle counter ----------------
    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    function automatic string nm(input int ch, input string s);
        return $sformatf("ch%0d_%s", ch, s);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic bit pop_exp(input int ch, output exp_t e);
        e = '0;
        if (ch == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); return 1'b1; end
        if (ch == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); return 1'b1; end
        if (ch == 2 && exp_q2.size() > 0) begin e = exp_q2.pop_front(); return 1'b1; end
        return 1'b0;
    endfunction

    // Reference: frame k of a run starts GAP_BITS bit periods after release,
    // then once per (frame bits + gap) period; it counts as delivered if its
    // stop bit is sampled mid-bit before reset comes back (n cycles later).
    task automatic push_run(input int n);
        exp_t e;
        for (int ch = 0; ch < 3; ch++) begin
            int bd, nb, k, st;
            bd = baud_a[ch];
            nb = nb_a[ch];
            k  = 0;
            st = 2 * bd;
            while (st + bd * (nb - 1) + bd / 2 <= n - 1) begin
                e.start = st;
                e.data  = msgs[k % 4];
                e.par   = ($countones(msgs[k % 4]) % 2) == 1;
                e.idx   = 2'(k % 4);
                if (ch == 0) exp_q0.push_back(e);
                else if (ch == 1) exp_q1.push_back(e);
                else exp_q2.push_back(e);
                k++;
                st += bd * (nb + 2);
            end
        end
    endtask

    // ---------------- monitor ----------------
    task automatic mon_step(input int ch, input logic t, input logic b, input logic [1:0] ix);
        int   bd, nb, rel, off, j;
        exp_t e;
        bd  = baud_a[ch];
        nb  = nb_a[ch];
        rel = cyc - rel_cyc;
        // every line change falls on a bit-period boundary
        if (t !== prev_t[ch]) chk(nm(ch, "edge_align"), rel % bd, 0);
        if (b) begin
            busy_run[ch]++;
        end else if (prev_b[ch]) begin
            chk(nm(ch, "busy_len"), busy_run[ch], bd * nb);
            busy_run[ch] = 0;
        end
        if (in_frame[ch] == 0 && prev_t[ch] == 1'b1 && t == 1'b0) begin
            in_frame[ch] = 1;
            start_c[ch]  = cyc;
            bits_a[ch]   = '0;
        end
        if (in_frame[ch] != 0) begin
            off = cyc - start_c[ch];
            if (off % bd == bd / 2) begin
                j = off / bd;
                bits_a[ch][j] = t;
                chk(nm(ch, "busy_mid"), int'(b), 1);
                if (j == 0) idx_seen[ch] = ix;
                if (j == nb - 1) begin
                    in_frame[ch] = 0;
                    if (!pop_exp(ch, e)) begin
                        chk(nm(ch, "unexpected_frame"), 1, 0);
                    end else begin
                        chk(nm(ch, "start_time"), start_c[ch] - rel_cyc, e.start);
                        chk(nm(ch, "start_bit"), int'(bits_a[ch][0]), 0);
                        chk(nm(ch, "data"), int'(bits_a[ch][8:1]), int'(e.data));
                        if (nb == 11) chk(nm(ch, "parity"), int'(bits_a[ch][9]), int'(e.par));
                        chk(nm(ch, "stop_bit"), int'(bits_a[ch][nb - 1]), 1);
                        chk(nm(ch, "byte_idx"), int'(idx_seen[ch]), int'(e.idx));
                    end
                end
            end
        end
        prev_t[ch] = t;
        prev_b[ch] = b;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            chk("ch0_rst_state", int'({txd0, busy0, idx0}), 8);
            chk("ch1_rst_state", int'({txd1, busy1, idx1}), 8);
            chk("ch2_rst_state", int'({txd2, busy2, idx2}), 8);
            for (int ch = 0; ch < 3; ch++) begin
                prev_t[ch]   = 1'b1;
                prev_b[ch]   = 1'b0;
                busy_run[ch] = 0;
                in_frame[ch] = 0;
            end
        end else if (reset === 1'b0) begin
            mon_step(0, txd0, busy0, idx0);
            mon_step(1, txd1, busy1, idx1);
            mon_step(2, txd2, busy2, idx2);
        end
    end

    // ---------------- driver ----------------
    // Release reset, let it run n cycles, then reset again mid-cycle and
    // confirm the line drops to mark at once.
    task automatic run(input int n);
        @(posedge clk);
        #5;
        reset   = 1'b0;
        rel_cyc = cyc;
        push_run(n);
        repeat (n) @(posedge clk);
        #5;
        reset = 1'b1;
        #1;
        chk("ch0_async_abort", int'({txd0, busy0, idx0}), 8);
        chk("ch1_async_abort", int'({txd1, busy1, idx1}), 8);
        chk("ch2_async_abort", int'({txd2, busy2, idx2}), 8);
        chk("ch0_frames_missing", exp_q0.size(), 0);
        chk("ch1_frames_missing", exp_q1.size(), 0);
        chk("ch2_frames_missing", exp_q2.size(), 0);
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
        repeat ($urandom_range(2, 5)) @(posedge clk);
    endtask

    initial begin
        reset = 1'b0;
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        // long run: many fast frames, five frames at BAUD_DIV=217
        run(15000);
        // ch0 frame 1 (0x55) is in data bit 3 (a 0 on the line) at cycle 77
        run(77);
        for (int r = 0; r < 20; r++) begin
            run($urandom_range(20, 700));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
